stg_ma_np: RTL and testbench

Parametrised memory-address stage sitting between EX and MO in the amber pipeline. It generalises the fixed two-port ping-pong scheme to NPORTS address ports and adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush, and a capability bounds check. Addresses are registered per port, and the port pointer advances only on accepted, non-faulting memory requests. This keeps stalls from desynchronising MA and MO.

---
 rtl/stg_ma_np_if.sv | 39 +++
 rtl/stg_ma_np.sv | 111 +++++++++++
 tb/tb_stg_ma_np.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stg_ma_np_if.sv
// Bus bundle for the MA stage: EX-side request/handshake in, MO-side entry and
// per-port address registers out. The master modport is the driver/observer side.
interface stg_ma_np_if #(
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned PAY_W  = 160,
    parameter int unsigned NPORTS = 2,
    parameter int unsigned PORT_W = $clog2(NPORTS)
);
    logic                     iw_flush;
    logic                     iw_valid;
    logic                     ow_ready;
    logic [PAY_W-1:0]         iw_payload;
    logic                     iw_mem_req;
    logic [ADDR_W-1:0]        iw_addr;
    logic [ADDR_W-1:0]        iw_cap_base;
    logic [ADDR_W-1:0]        iw_cap_len;
    logic                     ow_valid;
    logic                     iw_ready;
    logic [PAY_W-1:0]         ow_payload;
    logic                     ow_mem_req;
    logic                     ow_fault;
    logic [PORT_W-1:0]        ow_mem_port;
    logic [NPORTS*ADDR_W-1:0] ow_mem_addr;
    logic [NPORTS-1:0]        ow_mem_addr_vld;

    modport master (
        output iw_flush, iw_valid, iw_payload, iw_mem_req, iw_addr, iw_cap_base, iw_cap_len,
        output iw_ready,
        input  ow_ready, ow_valid, ow_payload, ow_mem_req, ow_fault, ow_mem_port, ow_mem_addr,
        input  ow_mem_addr_vld
    );

    modport slave (
        input  iw_flush, iw_valid, iw_payload, iw_mem_req, iw_addr, iw_cap_base, iw_cap_len,
        input  iw_ready,
        output ow_ready, ow_valid, ow_payload, ow_mem_req, ow_fault, ow_mem_port, ow_mem_addr,
        output ow_mem_addr_vld
    );
endinterface

// File: rtl/stg_ma_np.sv
// Memory-address stage: output register plus one skid entry, capability bounds
// check, and a round-robin pointer over NPORTS registered address ports.
module stg_ma_np #(
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned PAY_W  = 160,
    parameter int unsigned NPORTS = 2
) (
    input  logic        iw_clk,
    input  logic        iw_rst,
    stg_ma_np_if.slave  io_bus
);
    localparam int unsigned PORT_W = $clog2(NPORTS);

    typedef struct packed {
        logic [PAY_W-1:0]  pay;
        logic              mreq;
        logic              fault;
        logic [PORT_W-1:0] port;
    } entry_t;

    entry_t                          r_out, r_skid, w_out_nxt, w_skid_nxt, w_in;
    logic                            r_out_vld, r_skid_vld, w_out_vld_nxt, w_skid_vld_nxt;
    logic [PORT_W-1:0]               r_next, w_next_nxt;
    logic [NPORTS-1:0][ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [NPORTS-1:0]               r_addr_vld, w_addr_vld_nxt;

    logic [ADDR_W:0] w_cap_end;
    logic            w_fault, w_ready, w_accept, w_xfer;

    // End is one bit wider so base+len near the top of the space cannot wrap.
    assign w_cap_end = {1'b0, io_bus.iw_cap_base} + {1'b0, io_bus.iw_cap_len};
    assign w_fault   = io_bus.iw_mem_req &&
                       ((io_bus.iw_addr < io_bus.iw_cap_base) ||
                        ({1'b0, io_bus.iw_addr} >= w_cap_end));

    assign w_ready  = !r_skid_vld && !iw_rst;
    assign w_accept = io_bus.iw_valid && w_ready && !io_bus.iw_flush;
    assign w_xfer   = r_out_vld && io_bus.iw_ready;

    always_comb begin
        w_in           = '{pay: io_bus.iw_payload, mreq: io_bus.iw_mem_req && !w_fault,
                           fault: w_fault, port: r_next};
        w_out_nxt      = r_out;
        w_out_vld_nxt  = r_out_vld;
        w_skid_nxt     = r_skid;
        w_skid_vld_nxt = r_skid_vld;
        w_next_nxt     = r_next;
        w_mem_addr_nxt = r_mem_addr;
        w_addr_vld_nxt = r_addr_vld;

        if (io_bus.iw_flush) begin
            w_out_vld_nxt  = 1'b0;
            w_skid_vld_nxt = 1'b0;
            w_addr_vld_nxt = '0;
        end else begin
            if (w_xfer) begin
                if (r_out.mreq) w_addr_vld_nxt[r_out.port] = 1'b0;
                if (r_skid_vld) begin
                    w_out_nxt      = r_skid;
                    w_skid_vld_nxt = 1'b0;
                end else begin
                    w_out_vld_nxt  = 1'b0;
                end
            end
            // Accept implies SKID empty, so OUT is free whenever it is empty or leaving.
            if (w_accept) begin
                if (!r_out_vld || w_xfer) begin
                    w_out_nxt      = w_in;
                    w_out_vld_nxt  = 1'b1;
                end else begin
                    w_skid_nxt     = w_in;
                    w_skid_vld_nxt = 1'b1;
                end
                if (w_in.mreq) begin
                    w_mem_addr_nxt[r_next] = io_bus.iw_addr;
                    w_addr_vld_nxt[r_next] = 1'b1;
                    w_next_nxt = (r_next == PORT_W'(NPORTS - 1)) ? '0 : r_next + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
            r_next     <= '0;
            r_mem_addr <= '0;
            r_addr_vld <= '0;
        end else begin
            r_out      <= w_out_nxt;
            r_out_vld  <= w_out_vld_nxt;
            r_skid     <= w_skid_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_next     <= w_next_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_addr_vld <= w_addr_vld_nxt;
        end
    end

    assign io_bus.ow_ready        = w_ready;
    assign io_bus.ow_valid        = r_out_vld;
    assign io_bus.ow_payload      = r_out.pay;
    assign io_bus.ow_mem_req      = r_out.mreq;
    assign io_bus.ow_fault        = r_out.fault;
    assign io_bus.ow_mem_port     = r_out.port;
    assign io_bus.ow_mem_addr     = r_mem_addr;
    assign io_bus.ow_mem_addr_vld = r_addr_vld;
endmodule

// File: tb/tb_stg_ma_np.sv
// Bench for stg_ma_np: drives a 2-port and a 3-port instance with identical stimulus
// and checks both against a queue-level reference model plus hand-picked constants.
module tb_stg_ma_np;
    localparam int unsigned AW = 48;
    localparam int unsigned PW = 160;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          flush, valid, mreq, rdy_in;
    logic [PW-1:0] pay;
    logic [AW-1:0] addr, base, len;

    stg_ma_np_if #(.ADDR_W(AW), .PAY_W(PW), .NPORTS(2), .PORT_W(1)) if2 ();
    stg_ma_np_if #(.ADDR_W(AW), .PAY_W(PW), .NPORTS(3), .PORT_W(2)) if3 ();

    assign if2.iw_flush = flush;  assign if3.iw_flush = flush;
    assign if2.iw_valid = valid;  assign if3.iw_valid = valid;
    assign if2.iw_payload = pay;  assign if3.iw_payload = pay;
    assign if2.iw_mem_req = mreq; assign if3.iw_mem_req = mreq;
    assign if2.iw_addr = addr;    assign if3.iw_addr = addr;
    assign if2.iw_cap_base = base; assign if3.iw_cap_base = base;
    assign if2.iw_cap_len = len;  assign if3.iw_cap_len = len;
    assign if2.iw_ready = rdy_in; assign if3.iw_ready = rdy_in;

    stg_ma_np #(.ADDR_W(AW), .PAY_W(PW), .NPORTS(2)) u_dut2 (
        .iw_clk(clk), .iw_rst(rst), .io_bus(if2)
    );
    stg_ma_np #(.ADDR_W(AW), .PAY_W(PW), .NPORTS(3)) u_dut3 (
        .iw_clk(clk), .iw_rst(rst), .io_bus(if3)
    );

    // Reference model: an in-order FIFO of at most two entries per instance.
    typedef struct {
        logic [PW-1:0] pay;
        logic          mreq;
        logic          fault;
        int            port;
    } ent_t;

    ent_t          mq   [2][2];
    int            mcnt [2];
    int            mnext[2];
    logic [AW-1:0] maddr[2][3];
    logic          mvld [2][3];

    int checks;
    int errors;

    function automatic int np(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic void chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d]  = 0;
            mnext[d] = 0;
            for (int p = 0; p < 3; p++) begin
                maddr[d][p] = '0;
                mvld[d][p]  = 1'b0;
            end
        end
    endfunction

    // In range means base <= addr < base+len over unbounded integers.
    function automatic logic m_fault();
        logic [AW:0] lim;
        lim = {1'b0, base} + {1'b0, len};
        return mreq && ((addr < base) || ({1'b0, addr} >= lim));
    endfunction

    function automatic void m_edge();
        for (int d = 0; d < 2; d++) begin
            logic rdy, acc, xfer, f;
            ent_t e;
            rdy  = (mcnt[d] < 2);
            acc  = valid && rdy && !flush;
            xfer = (mcnt[d] > 0) && rdy_in;
            if (flush) begin
                mcnt[d] = 0;
                for (int p = 0; p < 3; p++) mvld[d][p] = 1'b0;
            end else begin
                if (xfer) begin
                    if (mq[d][0].mreq) mvld[d][mq[d][0].port] = 1'b0;
                    mq[d][0] = mq[d][1];
                    mcnt[d]--;
                end
                if (acc) begin
                    f       = m_fault();
                    e.pay   = pay;
                    e.mreq  = mreq && !f;
                    e.fault = f;
                    e.port  = mnext[d];
                    mq[d][mcnt[d]] = e;
                    mcnt[d]++;
                    if (e.mreq) begin
                        maddr[d][mnext[d]] = addr;
                        mvld[d][mnext[d]]  = 1'b1;
                        mnext[d] = (mnext[d] + 1) % np(d);
                    end
                end
            end
        end
    endfunction

    function automatic void cmp_all();
        for (int d = 0; d < 2; d++) begin
            logic          v, r, mr, f;
            logic [PW-1:0] p;
            int            port;
            logic [AW-1:0] a [3];
            logic          vl[3];
            if (d == 0) begin
                v = if2.ow_valid; r = if2.ow_ready; p = if2.ow_payload;
                mr = if2.ow_mem_req; f = if2.ow_fault; port = int'(if2.ow_mem_port);
                for (int k = 0; k < 2; k++) begin
                    a[k]  = if2.ow_mem_addr[k*AW +: AW];
                    vl[k] = if2.ow_mem_addr_vld[k];
                end
            end else begin
                v = if3.ow_valid; r = if3.ow_ready; p = if3.ow_payload;
                mr = if3.ow_mem_req; f = if3.ow_fault; port = int'(if3.ow_mem_port);
                for (int k = 0; k < 3; k++) begin
                    a[k]  = if3.ow_mem_addr[k*AW +: AW];
                    vl[k] = if3.ow_mem_addr_vld[k];
                end
            end
            chk($sformatf("n%0d ow_valid", np(d)), PW'(v), PW'(mcnt[d] > 0));
            chk($sformatf("n%0d ow_ready", np(d)), PW'(r), PW'(!rst && mcnt[d] < 2));
            if (mcnt[d] > 0) begin
                chk($sformatf("n%0d ow_payload", np(d)), p, mq[d][0].pay);
                chk($sformatf("n%0d ow_mem_req", np(d)), PW'(mr), PW'(mq[d][0].mreq));
                chk($sformatf("n%0d ow_fault", np(d)), PW'(f), PW'(mq[d][0].fault));
                chk($sformatf("n%0d ow_mem_port", np(d)), PW'(port), PW'(mq[d][0].port));
            end
            for (int k = 0; k < np(d); k++) begin
                chk($sformatf("n%0d mem_addr[%0d]", np(d), k), PW'(a[k]), PW'(maddr[d][k]));
                chk($sformatf("n%0d addr_vld[%0d]", np(d), k), PW'(vl[k]), PW'(mvld[d][k]));
            end
        end
    endfunction

    // Inputs are already set; compare pre-edge, then advance model and DUT together.
    task automatic step();
        cmp_all();
        @(posedge clk);
        if (rst) m_reset();
        else     m_edge();
        #1;
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic [AW-1:0] addr;
        logic          exp_fault;
    } bvec_t;

    typedef struct {
        logic mreq;
        int   exp_port3;
    } pvec_t;

    bvec_t bt[6];
    pvec_t pt[7];

    initial begin
        logic [63:0]  t;
        logic [191:0] wide;

        bt[0] = '{48'h1000, 48'h10, 48'h0FFF, 1'b1};
        bt[1] = '{48'h1000, 48'h10, 48'h100F, 1'b0};
        bt[2] = '{48'h1000, 48'h10, 48'h1010, 1'b1};
        bt[3] = '{48'hFFFF_FFFF_FFF0, 48'h20, 48'hFFFF_FFFF_FFFF, 1'b0};
        bt[4] = '{48'hFFFF_FFFF_FFF0, 48'h0, 48'hFFFF_FFFF_FFF0, 1'b1};
        bt[5] = '{48'h1000, 48'h10, 48'h1000, 1'b0};
        pt[0] = '{1'b1, 0}; pt[1] = '{1'b1, 1}; pt[2] = '{1'b1, 2}; pt[3] = '{1'b0, 0};
        pt[4] = '{1'b1, 0}; pt[5] = '{1'b1, 1}; pt[6] = '{1'b1, 2};

        checks = 0; errors = 0;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; mreq = 1'b0; rdy_in = 1'b0;
        pay = '0; addr = '0; base = '0; len = '0;
        m_reset();

        // Reset state
        #1;
        chk("rst ready n2", PW'(if2.ow_ready), PW'(0));
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready after rst", PW'(if2.ow_ready), PW'(1));
        step();

        // Stream 4 mem entries
        base = '0; len = 48'h1000; rdy_in = 1'b1; mreq = 1'b1; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 48'h100 + AW'(i);
            pay  = PW'(i + 1);
            step();
            chk("stream valid", PW'(if2.ow_valid), PW'(1));
            chk("stream port n2", PW'(if2.ow_mem_port), PW'(i % 2));
            chk("stream port n3", PW'(if3.ow_mem_port), PW'(i % 3));
        end
        chk("stream addr0 n2", PW'(if2.ow_mem_addr[47:0]), PW'(48'h102));
        chk("stream addr1 n2", PW'(if2.ow_mem_addr[95:48]), PW'(48'h103));
        valid = 1'b0;
        step();

        // Stall: A to OUT, B to SKID, C held off
        rdy_in = 1'b0; valid = 1'b1;
        pay = PW'(32'hA); addr = 48'h200; step();
        pay = PW'(32'hB); addr = 48'h201; step();
        pay = PW'(32'hC); addr = 48'h202; step();
        chk("stall ready", PW'(if2.ow_ready), PW'(0));
        chk("stall head", if2.ow_payload, PW'(32'hA));
        chk("stall port A n3", PW'(if3.ow_mem_port), PW'(1));
        chk("stall vld n2", PW'(if2.ow_mem_addr_vld), PW'(2'b11));
        rdy_in = 1'b1;
        step();
        chk("release B", if2.ow_payload, PW'(32'hB));
        chk("release B port n2", PW'(if2.ow_mem_port), PW'(1));
        step();
        chk("release C", if2.ow_payload, PW'(32'hC));
        chk("release C port n2", PW'(if2.ow_mem_port), PW'(0));
        chk("release C port n3", PW'(if3.ow_mem_port), PW'(0));
        valid = 1'b0;
        step();
        chk("drained", PW'(if2.ow_valid), PW'(0));

        // Bounds vectors
        mreq = 1'b1; valid = 1'b1; rdy_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            base = bt[i].base; len = bt[i].len; addr = bt[i].addr; pay = PW'(i + 16);
            step();
            chk($sformatf("bounds%0d fault", i), PW'(if2.ow_fault), PW'(bt[i].exp_fault));
            chk($sformatf("bounds%0d mem_req", i), PW'(if3.ow_mem_req), PW'(!bt[i].exp_fault));
        end
        valid = 1'b0;
        step();

        // Flush with OUT and SKID full and a live input
        base = '0; len = 48'h1000; rdy_in = 1'b0; valid = 1'b1;
        addr = 48'h300; pay = PW'(32'h300); step();
        addr = 48'h301; pay = PW'(32'h301); step();
        addr = 48'h302; pay = PW'(32'h302); flush = 1'b1; step();
        flush = 1'b0; valid = 1'b0;
        chk("flush valid", PW'(if2.ow_valid), PW'(0));
        chk("flush ready", PW'(if2.ow_ready), PW'(1));
        chk("flush vld n3", PW'(if3.ow_mem_addr_vld), PW'(0));
        rdy_in = 1'b1; valid = 1'b1; addr = 48'h303; step();
        valid = 1'b0; step();

        // Async reset in the middle of a stall
        rdy_in = 1'b0; valid = 1'b1; addr = 48'h400; step(); step();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("async rst valid", PW'(if2.ow_valid), PW'(0));
        chk("async rst vld", PW'(if3.ow_mem_addr_vld), PW'(0));
        cmp_all();
        valid = 1'b0;
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        step();

        // Three ports round-robin with a non-mem entry in the middle
        rdy_in = 1'b1; valid = 1'b1; base = '0; len = 48'h1000;
        for (int i = 0; i < 7; i++) begin
            mreq = pt[i].mreq; addr = 48'h500 + AW'(i); pay = PW'(i + 32);
            step();
            chk($sformatf("rr3 port %0d", i), PW'(if3.ow_mem_port), PW'(pt[i].exp_port3));
        end
        valid = 1'b0;
        step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            valid  = ($urandom_range(0, 3) != 0);
            rdy_in = ($urandom_range(0, 9) < 7);
            mreq   = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 24) == 0);
            t      = {$urandom, $urandom};
            base   = t[AW-1:0];
            if ($urandom_range(0, 7) == 0) base = 48'hFFFF_FFFF_FFE0;
            len    = AW'($urandom_range(0, 48));
            addr   = base + AW'($urandom_range(0, 64)) - AW'(8);
            wide   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pay    = wide[PW-1:0];
            step();
        end
        flush = 1'b0; valid = 1'b0; rdy_in = 1'b1;
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
